dot_frame_buffer: RTL
=====================

Name: dot_frame_buffer

Overview:
- Double-buffered 8x8 pixel store that sits directly upstream of the dot-matrix row-scan controller.
- The host side writes row bitmaps into a back buffer and requests a commit.
- The block swaps buffers only at a frame boundary signalled by the scanner, so no frame ever tears.
- It serves registered row data to the scanner, with optional horizontal rotate-scroll.

Parameters:
SCROLL_FRAMES, 16, frames displayed per one-column scroll step; legal range 1..255.

Ports:
clk  input  1  system clock (same domain as scanner's divided clock enable path)
reset  input  1  synchronous, active-low reset
wr_en  input  1  write strobe for back buffer
wr_addr  input  3  back-buffer row index, 0 = top row
wr_data  input  8  row bitmap; bit7 = leftmost column, 1 = LED on
commit  input  1  one-cycle request to swap buffers at next frame boundary
commit_pending  output  1  high from accepted commit until swap completes
rd_addr  input  3  row index requested by scanner
rd_data  output  8  registered row bitmap for rd_addr (front buffer, rotated)
frame_end  input  1  one-cycle pulse from scanner after last row (row 7) is shown
scroll_en  input  1  enables rotate-scroll
scroll_offset  output  3  current rotate amount, columns

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - both buffers all 8'h00; front_sel = 0
  - commit_pending = 0; scroll_offset = 0; internal frame_cnt = 0; rd_data = 8'h00
- Reset mid-operation: any queued commit is discarded, and both buffers are cleared.
- Writes:
  - wr_en = 1 writes wr_data into back[wr_addr] at the clock edge.
  - Writes are always accepted, including while commit_pending = 1.
  - A write in the swap cycle lands in the pre-swap back buffer, so it becomes visible immediately after the swap.
- Commit/swap:
  - commit with commit_pending = 0 sets commit_pending at the next edge.
  - commit with commit_pending = 1 is a no-op.
  - Swap occurs on an edge where frame_end = 1 and commit_pending = 1: front_sel toggles and commit_pending clears.
  - commit and frame_end in the same cycle with pending = 0: pending is set, no swap in that cycle; the swap happens at the following frame_end.
  - commit and frame_end in the same cycle with pending = 1: the swap happens and pending stays 1 (the new request is queued).
  - No copy on swap: the new back buffer retains the old front content.
- Read path:
  - rd_data <= rotl(front[rd_addr], scroll_offset) every cycle, giving 1-cycle latency.
  - The value is sampled using pre-edge front_sel and pre-edge scroll_offset.
  - rotl by k: {row[7-k:0], row[7:8-k]}; k = 0 gives the row unchanged.
- Scroll:
  - scroll_en = 1, on each frame_end: if frame_cnt == SCROLL_FRAMES-1, then frame_cnt <= 0 and scroll_offset <= scroll_offset+1 (wraps 7 -> 0); otherwise frame_cnt <= frame_cnt+1.
  - scroll_en = 0: frame_cnt <= 0 and scroll_offset holds.
  - A swap has priority: scroll_offset <= 0 and frame_cnt <= 0 regardless of scroll_en.
  - SCROLL_FRAMES = 1: offset advances on every frame_end.
- frame_end pulses longer than one cycle are counted once per high cycle; the scanner guarantees single-cycle pulses.
- No combinational path exists from any input to any output.

Test Plan:
1. Reset, then read rd_addr 0..7 -> rd_data = 8'h00 each, one cycle after the address is applied; commit_pending = 0; scroll_offset = 0.
2. Write back rows 0..7 = 18,24,42,C3,42,42,42,7E hex, no commit; read all rows -> rd_data still 00 (front untouched).
3. Write 8'hA5 to back row 3, pulse commit -> commit_pending = 1; read row 3 -> 00 until frame_end; at the frame_end edge pending -> 0; reading row 3 afterwards returns A5.
4. commit and frame_end in the same cycle with pending = 0 -> no swap and pending = 1; the next frame_end swaps. Repeat with pending = 1 -> the swap occurs and pending remains 1.
5. SCROLL_FRAMES = 2, front row 0 = 8'h81, scroll_en = 1, issue 4 frame_end pulses -> offset 0,1,1,2; rd_data row 0 = 81, 03, 03, 06.
6. Offset = 5 with a commit pending; frame_end -> swap, offset = 0, frame_cnt = 0. Assert reset mid-pending -> pending = 0, both buffers read 00.

Source files
------------

// File: rtl/dot_frame_buffer.sv
// rtl/dot_frame_buffer.sv - double-buffered 8x8 pixel store with tear-free swap and rotate-scroll
module dot_frame_buffer #(
    parameter int SCROLL_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       commit_pending,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       frame_end,
    input  logic       scroll_en,
    output logic [2:0] scroll_offset
);

    localparam logic [7:0] CNT_LAST = 8'(SCROLL_FRAMES - 1);

    logic [7:0] buf0 [8];
    logic [7:0] buf1 [8];
    logic       front_sel;
    logic [7:0] frame_cnt;
    logic [7:0] front_row;
    logic       swap;

    function automatic logic [7:0] rotl(input logic [7:0] row, input logic [2:0] k);
        logic [15:0] dbl;
        dbl = {row, row} << k;
        return dbl[15:8];
    endfunction

    assign front_row = front_sel ? buf1[rd_addr] : buf0[rd_addr];
    assign swap      = frame_end && commit_pending;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                buf0[i] <= 8'h00;
                buf1[i] <= 8'h00;
            end
            front_sel      <= 1'b0;
            commit_pending <= 1'b0;
            scroll_offset  <= 3'd0;
            frame_cnt      <= 8'd0;
            rd_data        <= 8'h00;
        end else begin
            // Back buffer is chosen by the pre-edge front_sel, so a write in
            // the swap cycle shows up on the new front immediately.
            if (wr_en) begin
                if (front_sel)
                    buf0[wr_addr] <= wr_data;
                else
                    buf1[wr_addr] <= wr_data;
            end

            rd_data <= rotl(front_row, scroll_offset);

            if (swap) begin
                front_sel      <= ~front_sel;
                commit_pending <= commit;
                scroll_offset  <= 3'd0;
                frame_cnt      <= 8'd0;
            end else begin
                if (commit)
                    commit_pending <= 1'b1;
                if (!scroll_en) begin
                    frame_cnt <= 8'd0;
                end else if (frame_end) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt     <= 8'd0;
                        scroll_offset <= scroll_offset + 3'd1;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
